// File: rtl/hack_pkg.sv
// Shared definitions for the HACK CPU control blocks: sequencer states and
// the C-instruction fields the sequencer and future pipelined core decode.
package hack_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int C_BIT  = 15;
  localparam int JMP_HI = 2;
  localparam int JMP_LO = 0;

  localparam logic [2:0] JMP_ALWAYS = 3'b111;

endpackage

// File: rtl/jump_cond.sv
// HACK jump decision: bits are {lt, eq, gt} selectors tested against the ALU flags.
module jump_cond (
  input  logic [2:0] jump,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  assign take = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute controller for the HACK program counter with halt-loop
// detection and a retired-instruction count.
//
// state | meaning
// INIT  | after async reset; clears the PC counter
// FETCH | requesting instruction at PC, waiting for imem_ack
// EXEC  | instruction valid; completes on first cycle without exec_stall
// HALT  | @n; 0;JMP-to-self seen; idle until cpu_reset_req
module pc_sequencer
  import hack_pkg::*;
#(
  parameter int width     = 16,
  parameter int cnt_width = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_reset_req,
  output logic                 imem_req,
  input  logic                 imem_ack,
  input  logic [width-1:0]     imem_data,
  output logic [width-1:0]     instr,
  output logic                 instr_valid,
  input  logic                 exec_stall,
  input  logic                 alu_zr,
  input  logic                 alu_ng,
  input  logic [width-1:0]     a_reg,
  input  logic [width-1:0]     pc_value,
  output logic                 pc_reset,
  output logic                 pc_load,
  output logic                 pc_inc,
  output logic                 halted,
  output logic [cnt_width-1:0] retired
);

  state_t state, state_nxt;
  logic   take;
  logic   is_c;
  logic   is_halt;
  logic   complete;
  logic   fetch_done;

  jump_cond u_jump_cond (
    .jump (instr[JMP_HI:JMP_LO]),
    .zr   (alu_zr),
    .ng   (alu_ng),
    .take (take)
  );

  assign is_c    = instr[C_BIT];
  assign is_halt = is_c && (instr[JMP_HI:JMP_LO] == JMP_ALWAYS) && (a_reg == pc_value);

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    pc_reset    = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    complete    = 1'b0;
    fetch_done  = 1'b0;

    case (state)
      ST_INIT: begin
        pc_reset  = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          fetch_done = 1'b1;
          state_nxt  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        instr_valid = 1'b1;
        if (!exec_stall) begin
          complete = 1'b1;
          if (is_halt) begin
            state_nxt = ST_HALT;
          end else begin
            pc_load   = is_c & take;
            pc_inc    = ~(is_c & take);
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = ST_INIT;
    endcase

    // Reset button abandons whatever is in flight, including a same-cycle ack.
    if (cpu_reset_req) begin
      pc_reset   = 1'b1;
      pc_load    = 1'b0;
      pc_inc     = 1'b0;
      imem_req   = 1'b0;
      complete   = 1'b0;
      fetch_done = 1'b0;
      state_nxt  = ST_FETCH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_INIT;
      instr   <= '0;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (cpu_reset_req) begin
        instr <= '0;
      end else if (fetch_done) begin
        instr <= imem_data;
      end
      if (complete) begin
        retired <= retired + cnt_width'(1);
      end
    end
  end

endmodule
